ahb_slave_interface: RTL and testbench

- AHB-side front end of the AHB-to-APB bridge, directly upstream of APB_Controller.
- Qualifies AHB transfers and decodes the peripheral select (tempselx).
- Pipelines address, write data and direction into the registered copies the controller consumes: Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg.
- Returns Prdata to the AHB master and generates the two-cycle AHB ERROR response for unmapped addresses.

---
 rtl/ahb_slave_interface.sv | 136 +++++++++++++
 tb/tb_ahb_slave_interface.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_interface.sv
// AHB-side front end of the AHB-to-APB bridge: transfer qualification, peripheral decode,
// address/data pipeline and the two-cycle ERROR response. Optional macro: AHB_ERR_RESP_EN.
module ahb_slave_interface #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 3
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Prdata,
  output logic              valid,
  output logic [NUM_SLV-1:0] tempselx,
  output logic [ADDR_W-1:0] Haddr1,
  output logic [ADDR_W-1:0] Haddr2,
  output logic [DATA_W-1:0] Hwdata1,
  output logic [DATA_W-1:0] Hwdata2,
  output logic              Hwritereg,
  output logic [DATA_W-1:0] Hrdata,
  output logic [1:0]        Hresp,
  output logic              Hready_err
);

  localparam logic [ADDR_W-1:0] SLV0_BASE = ADDR_W'(64'h8000_0000);
  localparam logic [ADDR_W-1:0] SLV1_BASE = ADDR_W'(64'h8400_0000);
  localparam logic [ADDR_W-1:0] SLV2_BASE = ADDR_W'(64'h8800_0000);
  localparam logic [ADDR_W-1:0] MAP_END   = ADDR_W'(64'h8C00_0000);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  logic              w_active;
  logic              w_mapped;
  logic              w_fsm_idle;
  logic [NUM_SLV-1:0] w_sel;

  logic [ADDR_W-1:0] r_haddr1;
  logic [ADDR_W-1:0] r_haddr2;
  logic [DATA_W-1:0] r_hwdata1;
  logic [DATA_W-1:0] r_hwdata2;
  logic              r_hwrite;

  // NONSEQ and SEQ carry a transfer; IDLE and BUSY never do
  assign w_active = Htrans[1];

  always_comb begin
    w_sel = '0;
    if ((Haddr >= SLV0_BASE) && (Haddr < SLV1_BASE)) w_sel[0] = 1'b1;
    if ((Haddr >= SLV1_BASE) && (Haddr < SLV2_BASE)) w_sel[1] = 1'b1;
    if ((Haddr >= SLV2_BASE) && (Haddr < MAP_END))   w_sel[2] = 1'b1;
  end

  assign w_mapped = |w_sel;
  assign tempselx = w_sel;
  assign valid    = Hreadyin & w_active & w_mapped & w_fsm_idle;
  assign Hrdata   = Prdata;

  // Pipeline shifts on every ready beat, IDLE beats included
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_haddr1  <= '0;
      r_haddr2  <= '0;
      r_hwdata1 <= '0;
      r_hwdata2 <= '0;
      r_hwrite  <= 1'b0;
    end else if (Hreadyin) begin
      r_haddr1  <= Haddr;
      r_haddr2  <= r_haddr1;
      r_hwdata1 <= Hwdata;
      r_hwdata2 <= r_hwdata1;
      r_hwrite  <= Hwrite;
    end
  end

  assign Haddr1    = r_haddr1;
  assign Haddr2    = r_haddr2;
  assign Hwdata1   = r_hwdata1;
  assign Hwdata2   = r_hwdata2;
  assign Hwritereg = r_hwrite;

`ifdef AHB_ERR_RESP_EN
  // state | meaning
  // IDLE  | no error pending, OKAY response, transfers may be accepted
  // ERR1  | first ERROR cycle, HREADY held low
  // ERR2  | second ERROR cycle, HREADY high; master cancels the next transfer
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_err_start;

  assign w_err_start = Hreadyin & w_active & ~w_mapped;

  always_ff @(posedge Hclk) begin
    if (Hreset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    Hresp       = RESP_OKAY;
    Hready_err  = 1'b1;
    w_fsm_idle  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_fsm_idle = 1'b1;
        if (w_err_start) w_state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        Hresp       = RESP_ERROR;
        Hready_err  = 1'b0;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        Hresp       = RESP_ERROR;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end
`else
  // Unmapped transfers are dropped silently; no response is ever generated
  assign w_fsm_idle = 1'b1;
  assign Hresp      = RESP_OKAY;
  assign Hready_err = 1'b1;
`endif

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Directed self-checking bench for ahb_slave_interface; error-response checks
// follow the build through AHB_ERR_RESP_EN.
module tb_ahb_slave_interface;

  logic        Hclk = 1'b0;
  logic        Hreset, Hwrite, Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr, Hwdata, Prdata;
  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
  logic        Hwritereg;
  logic [1:0]  Hresp;
  logic        Hready_err;

  int total = 0;
  int bad   = 0;

`ifdef AHB_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  ahb_slave_interface dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .valid(valid), .tempselx(tempselx), .Haddr1(Haddr1), .Haddr2(Haddr2),
    .Hwdata1(Hwdata1), .Hwdata2(Hwdata2), .Hwritereg(Hwritereg),
    .Hrdata(Hrdata), .Hresp(Hresp), .Hready_err(Hready_err)
  );

  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  logic [31:0] dec_addr [9] = '{32'h7FFF_FFFC, 32'h8000_0000, 32'h83FF_FFFF, 32'h8400_0000,
                                32'h87FF_FFFF, 32'h8800_0000, 32'h8BFF_FFFF, 32'h8C00_0000,
                                32'h9000_0000};
  logic [2:0]  dec_sel  [9] = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100,
                                3'b000, 3'b000};

  initial begin
    Hreset = 1'b1; Hwrite = 1'b1; Hreadyin = 1'b1; Htrans = 2'b10;
    Haddr = 32'h8000_0010; Hwdata = 32'hFFFF_FFFF; Prdata = 32'h0;
    step(); step();
    chk("rst_haddr1", Haddr1, 32'h0);
    chk("rst_haddr2", Haddr2, 32'h0);
    chk("rst_hwdata1", {31'b0, Hwdata1 == 32'h0}, 32'h1);
    chk("rst_hwritereg", {31'b0, Hwritereg}, 32'h0);
    chk("rst_hresp", {30'b0, Hresp}, 32'h0);
    chk("rst_hready_err", {31'b0, Hready_err}, 32'h1);

    // single write
    Hreset = 1'b0; Htrans = 2'b10; Hwrite = 1'b1; Haddr = 32'h8400_0004; Hwdata = 32'h0;
    #1;
    chk("wr_valid", {31'b0, valid}, 32'h1);
    chk("wr_sel", {29'b0, tempselx}, 32'h2);
    step();
    chk("wr_haddr1", Haddr1, 32'h8400_0004);
    chk("wr_hwritereg", {31'b0, Hwritereg}, 32'h1);
    Htrans = 2'b00; Hwrite = 1'b0; Haddr = 32'h0; Hwdata = 32'hA5A5_0001;
    step();
    chk("wr_hwdata1", Hwdata1, 32'hA5A5_0001);
    chk("wr_haddr2", Haddr2, 32'h8400_0004);
    chk("wr_idle_shift", Haddr1, 32'h0);

    // three-beat burst
    for (int i = 0; i < 3; i++) begin
      Haddr  = 32'h8000_0000 + 32'(4 * i);
      Htrans = (i == 0) ? 2'b10 : 2'b11;
      Hwdata = 32'h1000_0000 + 32'(i);
      #1;
      chk("burst_valid", {31'b0, valid}, 32'h1);
      chk("burst_sel", {29'b0, tempselx}, 32'h1);
      step();
      chk("burst_haddr1", Haddr1, 32'h8000_0000 + 32'(4 * i));
      if (i > 0) chk("burst_haddr2", Haddr2, 32'h8000_0000 + 32'(4 * (i - 1)));
    end

    // wait states
    Hreadyin = 1'b0; Haddr = 32'h8000_000C; Htrans = 2'b11; Hwdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ws_valid", {31'b0, valid}, 32'h0);
      step();
      chk("ws_haddr1", Haddr1, 32'h8000_0008);
      chk("ws_haddr2", Haddr2, 32'h8000_0004);
      chk("ws_hwdata1", Hwdata1, 32'h1000_0002);
      chk("ws_hwdata2", Hwdata2, 32'h1000_0001);
    end
    Hreadyin = 1'b1;
    #1;
    chk("ws_resume_valid", {31'b0, valid}, 32'h1);
    step();
    chk("ws_resume_haddr1", Haddr1, 32'h8000_000C);
    chk("ws_resume_haddr2", Haddr2, 32'h8000_0008);
    chk("ws_resume_hwdata1", Hwdata1, 32'hDEAD_BEEF);
    chk("ws_resume_hwdata2", Hwdata2, 32'h1000_0002);

    // decode boundaries, combinational only (no edge taken)
    Htrans = 2'b10; Hreadyin = 1'b1;
    for (int i = 0; i < 9; i++) begin
      Haddr = dec_addr[i];
      #1;
      chk("dec_sel", {29'b0, tempselx}, {29'b0, dec_sel[i]});
      chk("dec_valid", {31'b0, valid}, {31'b0, dec_sel[i] != 3'b000});
    end
    Haddr = 32'h8400_0000; Htrans = 2'b01;
    #1; chk("busy_valid", {31'b0, valid}, 32'h0);
    Htrans = 2'b00;
    #1; chk("idle_valid", {31'b0, valid}, 32'h0);
    Htrans = 2'b10; Hreadyin = 1'b0;
    #1; chk("notready_valid", {31'b0, valid}, 32'h0);
    Hreadyin = 1'b1; Prdata = 32'h1234_5678;
    #1; chk("hrdata", Hrdata, 32'h1234_5678);
    Prdata = 32'hCAFE_F00D;
    #1; chk("hrdata2", Hrdata, 32'hCAFE_F00D);

    // unmapped BUSY and unmapped without ready: no error
    Haddr = 32'h9000_0000; Htrans = 2'b01; Hreadyin = 1'b1;
    step();
    chk("busy_unm_hresp", {30'b0, Hresp}, 32'h0);
    Htrans = 2'b10; Hreadyin = 1'b0;
    step();
    chk("nrdy_unm_hresp", {30'b0, Hresp}, 32'h0);
    chk("nrdy_unm_hrdy", {31'b0, Hready_err}, 32'h1);

    // unmapped NONSEQ
    Hreadyin = 1'b1;
    #1;
    chk("unm_valid", {31'b0, valid}, 32'h0);
    chk("unm_sel", {29'b0, tempselx}, 32'h0);
    step();
    Haddr = 32'h8000_0000; Htrans = 2'b10;
    #1;
    chk("err1_hresp", {30'b0, Hresp}, ERR_EN ? 32'h1 : 32'h0);
    chk("err1_hrdy", {31'b0, Hready_err}, ERR_EN ? 32'h0 : 32'h1);
    chk("err1_valid", {31'b0, valid}, ERR_EN ? 32'h0 : 32'h1);
    step();
    chk("err2_hresp", {30'b0, Hresp}, ERR_EN ? 32'h1 : 32'h0);
    chk("err2_hrdy", {31'b0, Hready_err}, 32'h1);
    chk("err2_valid", {31'b0, valid}, ERR_EN ? 32'h0 : 32'h1);
    Htrans = 2'b00;
    step();
    chk("post_err_hresp", {30'b0, Hresp}, 32'h0);
    chk("post_err_hrdy", {31'b0, Hready_err}, 32'h1);

    // reset while in ERR1
    Haddr = 32'h9000_0000; Htrans = 2'b10;
    step();
    chk("rerr_err1_hresp", {30'b0, Hresp}, ERR_EN ? 32'h1 : 32'h0);
    Hreset = 1'b1; Htrans = 2'b00;
    step();
    chk("rerr_hresp", {30'b0, Hresp}, 32'h0);
    chk("rerr_hrdy", {31'b0, Hready_err}, 32'h1);
    chk("rerr_valid", {31'b0, valid}, 32'h0);
    chk("rerr_haddr1", Haddr1, 32'h0);
    Hreset = 1'b0;
    step();
    chk("rerr_after_hresp", {30'b0, Hresp}, 32'h0);
    Haddr = 32'h8800_0010; Htrans = 2'b10;
    #1;
    chk("rerr_after_valid", {31'b0, valid}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
